// File: rtl/pc_clk_pkg.sv
// Shared types and helpers for the processor-clock monitor.
// Holds the monitor state encoding and a width-agnostic saturating increment.
package pc_clk_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'b00,
    LOCKED = 2'b01,
    ERR    = 2'b10
  } state_e;

  localparam int MAX_CNT_W = 32;

  // Increments v and holds it at the all-ones value of a w-bit counter.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input int unsigned w);
    logic [MAX_CNT_W-1:0] mx;
    mx = (w >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << w) - MAX_CNT_W'(1));
    return (v >= mx) ? mx : v + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pc_clk_edge_det.sv
// Edge detector for a signal already synchronous to clk_i.
// Combinational rise/fall detect; strobes registered with one cycle latency.
module pc_clk_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_det_o,
  output logic fall_det_o,
  output logic rise_pulse_o,
  output logic fall_pulse_o
);

  logic d_q;
  logic rise_q;
  logic fall_q;

  // d_q clears on reset, so a high level in the first cycle reads as a rise.
  assign rise_det_o = sig_i & ~d_q;
  assign fall_det_o = ~sig_i & d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      d_q    <= sig_i;
      rise_q <= rise_det_o;
      fall_q <= fall_det_o;
    end
  end

  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;

endmodule

// File: rtl/pc_clk_monitor.sv
// Monitors the divided processor clock: edge strobes, period/high measurement,
// lock after consecutive good periods and a sticky error on stall or deviation.
module pc_clk_monitor
  import pc_clk_pkg::*;
#(
  parameter int EXP_PERIOD = 4,
  parameter int EXP_HIGH   = 2,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             err_clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             locked,
  output logic             err
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  logic             rise_det;
  logic             fall_det;

  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [1:0]       fall_cnt_q, fall_cnt_d;
  logic             seen_rise_q, seen_rise_d;
  logic             hi_ok_q, hi_ok_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  state_e           state_q, state_d;
  logic             locked_q, err_q;

  logic             good_per;
  logic             fault;

  pc_clk_edge_det u_edge (
    .clk_i        (clk_in),
    .rst_i        (rst),
    .sig_i        (div_clk),
    .rise_det_o   (rise_det),
    .fall_det_o   (fall_det),
    .rise_pulse_o (rise_pulse),
    .fall_pulse_o (fall_pulse)
  );

  always_comb begin
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    period_d    = period_q;
    high_d      = high_q;
    fall_cnt_d  = fall_cnt_q;
    seen_rise_d = seen_rise_q;
    hi_ok_d     = hi_ok_q;

    if (rise_det) begin
      if (seen_rise_q) period_d = per_cnt_q;
      per_cnt_d   = CNT_W'(1);
      hi_cnt_d    = CNT_W'(1);
      seen_rise_d = 1'b1;
      fall_cnt_d  = 2'd0;
    end else begin
      per_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(per_cnt_q), CNT_W));
      if (div_clk && !fall_det) hi_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(hi_cnt_q), CNT_W));
    end

    if (fall_det && seen_rise_q) begin
      high_d     = hi_cnt_q;
      hi_ok_d    = (hi_cnt_q == CNT_W'(EXP_HIGH));
      fall_cnt_d = (fall_cnt_q == 2'd2) ? 2'd2 : fall_cnt_q + 2'd1;
    end
  end

  // A saturated per_cnt can never equal EXP_PERIOD, so it is always bad.
  assign good_per = rise_det && seen_rise_q && (per_cnt_q == CNT_W'(EXP_PERIOD))
                    && (fall_cnt_q == 2'd1) && hi_ok_q;
  assign fault    = (rise_det && seen_rise_q && !good_per)
                    || (!rise_det && seen_rise_q && (per_cnt_q >= CNT_W'(EXP_PERIOD)));

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    unique case (state_q)
      ACQ: begin
        if (good_per) begin
          good_cnt_d = good_cnt_q + GW'(1);
          if (int'(good_cnt_q) + 1 == LOCK_COUNT) state_d = LOCKED;
        end else if (fault) begin
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (fault) state_d = ERR;
      end
      ERR: begin
        if (err_clr) begin
          state_d    = ACQ;
          good_cnt_d = '0;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      period_q    <= '0;
      high_q      <= '0;
      fall_cnt_q  <= '0;
      seen_rise_q <= 1'b0;
      hi_ok_q     <= 1'b0;
      good_cnt_q  <= '0;
      state_q     <= ACQ;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      fall_cnt_q  <= fall_cnt_d;
      seen_rise_q <= seen_rise_d;
      hi_ok_q     <= hi_ok_d;
      good_cnt_q  <= good_cnt_d;
      state_q     <= state_d;
      locked_q    <= (state_d == LOCKED);
      err_q       <= (state_d == ERR);
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pc_clk_monitor.sv
// Drives two monitors (8-bit and 3-bit counters) with shared stimulus and checks
// both against a timestamp-based reference model every cycle.
module tb_pc_clk_monitor;

  localparam int EXP_PERIOD = 4;
  localparam int EXP_HIGH   = 2;
  localparam int LOCK_COUNT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic div_clk = 1'b0;
  logic err_clr = 1'b0;

  logic       a_rise, a_fall, a_locked, a_err;
  logic [7:0] a_period, a_high;
  logic       b_rise, b_fall, b_locked, b_err;
  logic [2:0] b_period, b_high;

  pc_clk_monitor #(.EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH), .LOCK_COUNT(LOCK_COUNT), .CNT_W(8)) dut_a (
    .clk_in(clk), .rst(rst), .div_clk(div_clk), .err_clr(err_clr),
    .rise_pulse(a_rise), .fall_pulse(a_fall), .period_out(a_period), .high_out(a_high),
    .locked(a_locked), .err(a_err)
  );

  pc_clk_monitor #(.EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH), .LOCK_COUNT(LOCK_COUNT), .CNT_W(3)) dut_b (
    .clk_in(clk), .rst(rst), .div_clk(div_clk), .err_clr(err_clr),
    .rise_pulse(b_rise), .fall_pulse(b_fall), .period_out(b_period), .high_out(b_high),
    .locked(b_locked), .err(b_err)
  );

  // Reference: remembers when the last rise happened and derives lengths from timestamps.
  typedef struct packed {
    int   cyc;
    int   last_rise;
    int   falls;
    int   good;
    int   st;        // 0 acquiring, 1 locked, 2 error
    int   period_o;
    int   high_o;
    logic d_prev;
    logic hi_ok;
    logic rise_o;
    logic fall_o;
  } ms_t;

  ms_t ma, mb;
  int  errors = 0;
  int  checks = 0;
  int  cyc_n  = 0;

  function automatic ms_t mstep(ms_t s, int maxv, logic dv, logic clr, logic rs);
    ms_t  n;
    int   el;
    int   hl;
    logic rise, fall, seen, good, fault;
    n = s;
    n.cyc = s.cyc + 1;
    if (rs) begin
      n = '0;
      n.cyc = s.cyc + 1;
      n.last_rise = -1;
      return n;
    end
    seen = (s.last_rise >= 0);
    el = seen ? (s.cyc - s.last_rise) : 0;
    if (el > maxv) el = maxv;
    rise = dv && !s.d_prev;
    fall = !dv && s.d_prev;
    good = 1'b0;
    fault = 1'b0;
    n.rise_o = rise;
    n.fall_o = fall;
    if (rise) begin
      if (seen) begin
        n.period_o = el;
        good = (el == EXP_PERIOD) && (s.falls == 1) && s.hi_ok;
        fault = !good;
      end
      n.last_rise = s.cyc;
      n.falls = 0;
    end else if (seen && el >= EXP_PERIOD) begin
      fault = 1'b1;
    end
    if (fall && seen) begin
      hl = s.cyc - s.last_rise;
      if (hl > maxv) hl = maxv;
      n.high_o = hl;
      n.hi_ok = (hl == EXP_HIGH);
      n.falls = (s.falls >= 2) ? 2 : s.falls + 1;
    end
    case (s.st)
      0: begin
        if (good) begin
          if (s.good + 1 == LOCK_COUNT) n.st = 1;
          n.good = s.good + 1;
        end else if (fault) n.good = 0;
      end
      1: if (fault) n.st = 2;
      default: if (clr) begin n.st = 0; n.good = 0; end
    endcase
    n.d_prev = dv;
    return n;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_n, got, exp);
    end
  endtask

  task automatic check_set(input string p, input ms_t m, input int rp, input int fp,
                           input int per, input int hi, input int lk, input int er);
    chk({p, ".rise_pulse"}, rp, int'(m.rise_o));
    chk({p, ".fall_pulse"}, fp, int'(m.fall_o));
    chk({p, ".period_out"}, per, m.period_o);
    chk({p, ".high_out"}, hi, m.high_o);
    chk({p, ".locked"}, lk, int'(m.st == 1));
    chk({p, ".err"}, er, int'(m.st == 2));
  endtask

  task automatic step(input logic dv, input logic clr, input logic rs);
    div_clk = dv;
    err_clr = clr;
    rst = rs;
    @(posedge clk);
    ma = mstep(ma, 255, dv, clr, rs);
    mb = mstep(mb, 7, dv, clr, rs);
    #1;
    cyc_n++;
    check_set("A", ma, int'(a_rise), int'(a_fall), int'(a_period), int'(a_high),
              int'(a_locked), int'(a_err));
    check_set("B", mb, int'(b_rise), int'(b_fall), int'(b_period), int'(b_high),
              int'(b_locked), int'(b_err));
  endtask

  // reps periods of hi high cycles then lo low cycles; err_clr on the first cycle of rep clr_rep.
  task automatic pat(input int hi, input int lo, input int reps, input int clr_rep);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < hi + lo; k++)
        step(k < hi, (r == clr_rep) && (k == 0), 1'b0);
    end
  endtask

  initial begin
    ma = '0; ma.last_rise = -1;
    mb = '0; mb.last_rise = -1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    pat(2, 2, 5, -1);       // clean lock
    pat(8, 2, 1, -1);       // stall high while locked
    pat(2, 2, 3, -1);       // error stays sticky
    pat(2, 2, 6, 0);        // clear in error, relock
    pat(2, 2, 2, 1);        // clear while locked is ignored
    step(1'b0, 1'b0, 1'b1);
    pat(1, 3, 13, -1);      // wrong duty, never locks
    pat(2, 2, 5, -1);
    step(1'b1, 1'b0, 1'b1); // reset while locked
    pat(2, 2, 5, -1);
    pat(0, 20, 1, -1);      // long low: saturates the narrow counter
    pat(2, 2, 3, -1);
    for (int s = 0; s < 60; s++) begin
      int hi, lo, reps, cr;
      if ($urandom_range(0, 1) == 0) begin
        hi = 2; lo = 2;
      end else begin
        hi = $urandom_range(1, 5); lo = $urandom_range(1, 5);
      end
      reps = $urandom_range(1, 4);
      cr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, reps - 1) : -1;
      pat(hi, lo, reps, cr);
      if ($urandom_range(0, 15) == 0) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_clk_monitor.md
Name: pc_clk_monitor

Overview:
- Sits on the consuming end of the 4:1 processor-clock divider.
- Samples the divided clock in the fast clock domain and emits one-cycle rise/fall strobes for pipeline stages clocked by `clk_in`.
- Measures the period and high time of every slow cycle.
- Declares lock after consecutive good cycles and raises a sticky error on stall or duty/period deviation.

Parameters:
- EXP_PERIOD, 4, expected slow-clock period in `clk_in` cycles.
- EXP_HIGH, 2, expected high time in `clk_in` cycles.
- LOCK_COUNT, 3, consecutive good periods required to lock.
- CNT_W, 8, width of the period and high counters. Must satisfy 2^CNT_W-1 > EXP_PERIOD.

Ports:
- clk_in  input  1  fast system clock.
- rst  input  1  synchronous, active-high reset.
- div_clk  input  1  divided clock, generated from clk_in (already synchronous, no synchronizer).
- err_clr  input  1  one-cycle request to clear the error state.
- rise_pulse  output  1  one-cycle strobe, registered, one cycle after rising edge detected.
- fall_pulse  output  1  one-cycle strobe, registered, one cycle after falling edge detected.
- period_out  output  CNT_W  last completed period length.
- high_out  output  CNT_W  last measured high time.
- locked  output  1  high while in LOCKED.
- err  output  1  sticky, high while in ERR.

Behaviour:
- Reset: d_q, per_cnt, hi_cnt, good_cnt, seen_rise and fall_cnt all clear. All outputs 0. State = ACQ. Reset mid-operation discards all history; the next cycle behaves as first after reset.
- Edge detect: d_q = div_clk delayed 1 cycle.
  - rise_det = div_clk & ~d_q; fall_det = ~div_clk & d_q (combinational).
  - rise_pulse and fall_pulse are those values registered (latency 1).
  - If div_clk is 1 in the first cycle after reset, it counts as a rise.
- per_cnt:
  - On rise_det: if seen_rise, period_out <= per_cnt. Then per_cnt <= 1, seen_rise <= 1, fall_cnt <= 0.
  - Otherwise per_cnt <= per_cnt+1, saturating at all-ones.
  - Example: pattern 1100 gives period_out = 4.
- hi_cnt:
  - On rise_det: hi_cnt <= 1.
  - While div_clk = 1 and no edge: hi_cnt increments, saturating.
  - On fall_det with seen_rise: high_out <= hi_cnt and fall_cnt increments (saturating at 2).
  - Example: pattern 1100 gives high_out = 2.
- Good period: evaluated on rise_det with seen_rise. Good iff:
  - per_cnt == EXP_PERIOD, and
  - fall_cnt == 1, and
  - the high_out captured at that fall == EXP_HIGH (tracked by hi_ok flag).
- Timeout: no rise_det while per_cnt >= EXP_PERIOD and seen_rise.
- FSM (states ACQ, LOCKED, ERR):
  - ACQ:
    - Good period: good_cnt++. When good_cnt+1 == LOCK_COUNT, go to LOCKED.
    - Bad period or timeout: good_cnt <= 0.
  - LOCKED:
    - Bad period or timeout: go to ERR.
    - good_cnt frozen.
  - ERR:
    - err_clr: go to ACQ, good_cnt <= 0.
    - err_clr and a fault in the same cycle: clear wins.
    - Faults in ERR have no further effect.
  - err_clr in ACQ or LOCKED is ignored.
- locked and err are registered decodes of the next state. They update in the cycle after the deciding edge or timeout.
- Saturated counters never wrap. A saturated period is reported as all-ones and is always bad.

Decomposition:
- Package pc_clk_pkg holds:
  - state enum: ACQ = 2'b00, LOCKED = 2'b01, ERR = 2'b10;
  - a CNT_W saturating-increment function.
- One natural sub-module: pc_clk_edge_det. It holds d_q and the rise/fall detect plus registered strobes, so it is reusable by other stages.

Test Plan:
1. Reset, then div_clk pattern 1100 repeated, first rise at cycle 0:
   - rise_pulse at cycles 1, 5, 9, 13; fall_pulse at 3, 7, 11;
   - period_out = 4 from cycle 5; high_out = 2 from cycle 3;
   - locked = 1 from cycle 13; err = 0.
2. While locked, hold div_clk at 1 for 8 cycles after a rise at cycle t:
   - per_cnt reaches 4 with no rise at cycle t+4;
   - err = 1 and locked = 0 at cycle t+5; both stay even after the pattern resumes.
3. Pattern 1000 repeated:
   - period_out = 4, high_out = 1;
   - locked never asserts over 50 cycles; err stays 0 (still ACQ).
4. In ERR, pulse err_clr with clean 1100:
   - err = 0 the next cycle;
   - locked reasserts one cycle after the 3rd subsequent good period.
   - err_clr pulsed while LOCKED leaves locked = 1.
5. Locked, then assert rst for 1 cycle:
   - all outputs 0 the next cycle; period_out = 0;
   - relock requires a fresh first rise plus 3 good periods.
6. CNT_W = 3, hold div_clk low for 20 cycles, then rise:
   - period_out = 7 (saturated, no wrap);
   - if in LOCKED, err = 1.
